// File: rtl/grn_attractor_ctrl_if.sv
// Bundle of the signals between grn_attractor_ctrl and the blocks around it:
// the initial-state stream, the node bank control/feedback and the result stream.
// master = the controller, slave = the stream source / node bank / result sink.
interface grn_attractor_ctrl_if #(
  parameter int N_NODES = 8,
  parameter int CNT_W   = 16
);
  logic               init_valid;
  logic               init_ready;
  logic [N_NODES-1:0] init_data;
  logic               reset_nos;
  logic [N_NODES-1:0] init_state;
  logic               start_s0;
  logic               start_s1;
  logic [N_NODES-1:0] s0_vec;
  logic [N_NODES-1:0] s1_vec;
  logic               res_valid;
  logic               res_ready;
  logic [CNT_W-1:0]   res_steps;
  logic [CNT_W-1:0]   res_period;
  logic [N_NODES-1:0] res_state;
  logic               res_timeout;

  modport master (
    input  init_valid, init_data, s0_vec, s1_vec, res_ready,
    output init_ready, reset_nos, init_state, start_s0, start_s1,
           res_valid, res_steps, res_period, res_state, res_timeout
  );

  modport slave (
    output init_valid, init_data, s0_vec, s1_vec, res_ready,
    input  init_ready, reset_nos, init_state, start_s0, start_s1,
           res_valid, res_steps, res_period, res_state, res_timeout
  );
endinterface

// File: rtl/grn_attractor_ctrl.sv
// Boolean-network attractor search controller.
// Loads an initial state into the node bank, steps the tortoise (s0) and hare (s1)
// trajectories until they meet at an even hare step (Floyd), then steps the hare alone
// until it returns to the meeting state to measure the attractor period.
// Optional step limit: define GRN_TIMEOUT_EN to abort searches after MAX_STEPS.
// All outputs are registered.
module grn_attractor_ctrl #(
  parameter int N_NODES   = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 1024
) (
  input  logic clk,
  input  logic rst,
  grn_attractor_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    PULSE   = 3'd2,
    CHECK   = 3'd3,
    P_PULSE = 3'd4,
    P_CHECK = 3'd5,
    RESULT  = 3'd6
  } state_e;

  state_e             state_q;
  logic               init_ready_q;
  logic               reset_nos_q;
  logic               start_s0_q;
  logic               start_s1_q;
  logic               res_valid_q;
  logic [N_NODES-1:0] init_state_q;
  logic [N_NODES-1:0] res_state_q;
  logic [CNT_W-1:0]   steps_q;
  logic [CNT_W-1:0]   period_q;
  logic [CNT_W-1:0]   res_steps_q;
  logic [CNT_W-1:0]   res_period_q;

`ifdef GRN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] STEP_LIMIT = CNT_W'(MAX_STEPS);
  logic res_timeout_q;
  assign bus.res_timeout = res_timeout_q;
`else
  assign bus.res_timeout = 1'b0;
`endif

  assign bus.init_ready = init_ready_q;
  assign bus.reset_nos  = reset_nos_q;
  assign bus.init_state = init_state_q;
  assign bus.start_s0   = start_s0_q;
  assign bus.start_s1   = start_s1_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_steps  = res_steps_q;
  assign bus.res_period = res_period_q;
  assign bus.res_state  = res_state_q;

  // Search FSM: strobes are raised on entry to the state in which they are visible,
  // so each strobe lasts exactly the one cycle spent in LOAD / PULSE / P_PULSE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      init_ready_q <= 1'b0;
      reset_nos_q  <= 1'b0;
      start_s0_q   <= 1'b0;
      start_s1_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      init_state_q <= {N_NODES{1'b0}};
      res_state_q  <= {N_NODES{1'b0}};
      steps_q      <= {CNT_W{1'b0}};
      period_q     <= {CNT_W{1'b0}};
      res_steps_q  <= {CNT_W{1'b0}};
      res_period_q <= {CNT_W{1'b0}};
`ifdef GRN_TIMEOUT_EN
      res_timeout_q <= 1'b0;
`endif
    end else begin
      reset_nos_q <= 1'b0;
      start_s0_q  <= 1'b0;
      start_s1_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (init_ready_q && bus.init_valid) begin
            init_ready_q <= 1'b0;
            init_state_q <= bus.init_data;
            reset_nos_q  <= 1'b1;
            state_q      <= LOAD;
          end else begin
            init_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          steps_q    <= {CNT_W{1'b0}};
          period_q   <= {CNT_W{1'b0}};
          start_s0_q <= 1'b1;
          start_s1_q <= 1'b1;
          state_q    <= PULSE;
        end
        PULSE: begin
          steps_q <= steps_q + CNT_W'(1);
          state_q <= CHECK;
        end
        CHECK: begin
          // Odd-step coincidences are artefacts of s0 advancing on the first request.
          if ((steps_q[0] == 1'b0) && (bus.s0_vec == bus.s1_vec)) begin
            res_state_q <= bus.s0_vec;
            res_steps_q <= steps_q;
            start_s1_q  <= 1'b1;
            state_q     <= P_PULSE;
`ifdef GRN_TIMEOUT_EN
          end else if (steps_q == STEP_LIMIT) begin
            res_state_q   <= bus.s0_vec;
            res_steps_q   <= steps_q;
            res_period_q  <= {CNT_W{1'b0}};
            res_timeout_q <= 1'b1;
            res_valid_q   <= 1'b1;
            state_q       <= RESULT;
`endif
          end else begin
            start_s0_q <= 1'b1;
            start_s1_q <= 1'b1;
            state_q    <= PULSE;
          end
        end
        P_PULSE: begin
          period_q <= period_q + CNT_W'(1);
          state_q  <= P_CHECK;
        end
        P_CHECK: begin
          if (bus.s1_vec == res_state_q) begin
            res_period_q <= period_q;
            res_valid_q  <= 1'b1;
            state_q      <= RESULT;
`ifdef GRN_TIMEOUT_EN
            res_timeout_q <= 1'b0;
          end else if (period_q == STEP_LIMIT) begin
            res_period_q  <= period_q;
            res_timeout_q <= 1'b1;
            res_valid_q   <= 1'b1;
            state_q       <= RESULT;
`endif
          end else begin
            start_s1_q <= 1'b1;
            state_q    <= P_PULSE;
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            res_valid_q  <= 1'b0;
            init_ready_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            res_valid_q <= 1'b1;
          end
        end
        default: begin
          init_ready_q <= 1'b0;
          res_valid_q  <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Directed bench for grn_attractor_ctrl with a behavioural node bank.
// Default build: 3-node rotate-left network. With GRN_TIMEOUT_EN: 4-bit counter
// network and MAX_STEPS=4.
module tb_grn_attractor_ctrl;

`ifdef GRN_TIMEOUT_EN
  localparam int N  = 4;
  localparam int MS = 4;
`else
  localparam int N  = 3;
  localparam int MS = 1024;
`endif
  localparam int CW = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  grn_attractor_ctrl_if #(.N_NODES(N), .CNT_W(CW)) bus ();

  grn_attractor_ctrl #(.N_NODES(N), .CNT_W(CW), .MAX_STEPS(MS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Node bank model: s1 advances on every request, s0 on every 2nd request (first one included).
  logic [N-1:0] s0_m;
  logic [N-1:0] s1_m;
  logic         tog_m;

  function automatic logic [N-1:0] nxt(input logic [N-1:0] s);
`ifdef GRN_TIMEOUT_EN
    return s + N'(1);
`else
    return {s[N-2:0], s[N-1]};
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (bus.reset_nos) begin
      s0_m  <= bus.init_state;
      s1_m  <= bus.init_state;
      tog_m <= 1'b0;
    end else begin
      if (bus.start_s1) s1_m <= nxt(s1_m);
      if (bus.start_s0) begin
        if (!tog_m) s0_m <= nxt(s0_m);
        tog_m <= ~tog_m;
      end
    end
  end

  assign bus.s0_vec = s0_m;
  assign bus.s1_vec = s1_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one initial state and wait for the result; lat counts edges from the accept edge.
  task automatic run(input logic [N-1:0] d, input bit hold, output int lat, output int pulses);
    bus.init_data  = d;
    bus.init_valid = 1'b1;
    lat    = 0;
    pulses = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!hold) bus.init_valid = 1'b0;
      if (bus.reset_nos) pulses++;
    end while (!bus.res_valid && lat < 300);
    check("res_valid_seen", 32'(bus.res_valid), 32'd1);
  endtask

  initial begin
    int lat;
    int pulses;
    int cnt;
    n_cmp = 0;
    n_err = 0;
    rst            = 1'b1;
    bus.init_valid = 1'b0;
    bus.init_data  = '0;
    bus.res_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_init_ready", 32'(bus.init_ready), 32'd0);
    check("rst_res_valid",  32'(bus.res_valid),  32'd0);
    check("rst_strobes",    32'({bus.reset_nos, bus.start_s0, bus.start_s1}), 32'd0);
    check("rst_res_steps",  32'(bus.res_steps),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.init_ready), 32'd1);

`ifdef GRN_TIMEOUT_EN
    // Counter network from 0: no even-step meeting before the limit of 4 steps.
    run(4'd0, 1'b0, lat, pulses);
    check("to_timeout", 32'(bus.res_timeout), 32'd1);
    check("to_steps",   32'(bus.res_steps),   32'd4);
    check("to_period",  32'(bus.res_period),  32'd0);
    check("to_state",   32'(bus.res_state),   32'd2);
    check("to_latency", 32'(lat),             32'd10);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("to_done_valid", 32'(bus.res_valid),  32'd0);
    check("to_done_ready", 32'(bus.init_ready), 32'd1);
`else
    // Reset held 3 cycles while the hare steps alone.
    bus.init_data  = 3'b001;
    bus.init_valid = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      bus.init_valid = 1'b0;
      cnt++;
    end while (!(bus.start_s1 && !bus.start_s0 && !bus.reset_nos) && cnt < 100);
    check("reach_p_pulse", 32'(bus.start_s1 && !bus.start_s0), 32'd1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_ready",   32'(bus.init_ready), 32'd0);
    check("mid_rst_valid",   32'(bus.res_valid),  32'd0);
    check("mid_rst_strobes", 32'({bus.reset_nos, bus.start_s0, bus.start_s1}), 32'd0);
    check("mid_rst_period",  32'(bus.res_period), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_idle", 32'(bus.init_ready), 32'd1);

    // Fixed point 000.
    run(3'b000, 1'b0, lat, pulses);
    check("fp_latency", 32'(lat),             32'd8);
    check("fp_steps",   32'(bus.res_steps),   32'd2);
    check("fp_period",  32'(bus.res_period),  32'd1);
    check("fp_state",   32'(bus.res_state),   32'd0);
    check("fp_timeout", 32'(bus.res_timeout), 32'd0);
    check("fp_loads",   32'(pulses),          32'd1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("fp_done_valid", 32'(bus.res_valid),  32'd0);
    check("fp_done_ready", 32'(bus.init_ready), 32'd1);

    // 3-cycle ring from 001: the odd-step match at step 1 must not stop the search.
    run(3'b001, 1'b0, lat, pulses);
    check("ring_latency", 32'(lat),            32'd20);
    check("ring_steps",   32'(bus.res_steps),  32'd6);
    check("ring_period",  32'(bus.res_period), 32'd3);
    check("ring_state",   32'(bus.res_state),  32'd1);

    // Result held under back-pressure.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid",  32'(bus.res_valid),  32'd1);
      check("bp_fields", 32'({bus.res_steps, bus.res_period[7:0], 5'(bus.res_state)}),
                         32'({16'd6, 8'd3, 5'd1}));
      check("bp_ready",  32'(bus.init_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("bp_done_valid", 32'(bus.res_valid),  32'd0);
    check("bp_done_ready", 32'(bus.init_ready), 32'd1);

    // Back-to-back: valid stays high across both searches.
    run(3'b000, 1'b1, lat, pulses);
    check("b2b1_steps",  32'(bus.res_steps),  32'd2);
    check("b2b1_period", 32'(bus.res_period), 32'd1);
    check("b2b1_loads",  32'(pulses),         32'd1);
    bus.init_data = 3'b011;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("b2b_idle", 32'(bus.init_ready), 32'd1);
    run(3'b011, 1'b0, lat, pulses);
    check("b2b2_latency", 32'(lat),            32'd20);
    check("b2b2_steps",   32'(bus.res_steps),  32'd6);
    check("b2b2_period",  32'(bus.res_period), 32'd3);
    check("b2b2_state",   32'(bus.res_state),  32'd3);
    check("b2b2_loads",   32'(pulses),         32'd1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("b2b_done_valid", 32'(bus.res_valid), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
